// File: rtl/b_req_responder.sv
// B-side request endpoint: buffers incoming requests in a FIFO, reads memory
// for each one in order and returns address+data on a ready/valid channel.
module b_req_responder #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Valid,
  input  logic [ADDR_W-1:0]             Address,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  input  logic [DATA_W-1:0]             mem_rd_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ADDR_W-1:0]             resp_addr,
  output logic [DATA_W-1:0]             resp_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_err,
  output logic [7:0]                    drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign fifo_empty  = (fifo_level == '0);
  assign fifo_full   = (fifo_level == FULL_LEVEL);
  assign pop         = (state == IDLE) && !fifo_empty;
  assign push        = Valid && (!fifo_full || pop);
  assign drop        = Valid && fifo_full && !pop;
  assign mem_rd_en   = pop;
  assign mem_rd_addr = pop ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      resp_valid   <= 1'b0;
      resp_addr    <= '0;
      resp_data    <= '0;
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= Address;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      // Dropped requests are remembered until the next reset; the counter saturates.
      if (drop) begin
        overflow_err <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pop) begin
            resp_addr <= fifo_mem[rd_ptr];
            state     <= WAIT;
          end
        end
        WAIT: begin
          resp_data  <= mem_rd_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b_req_responder.sv
// Directed bench for b_req_responder: expected responses are queued at issue
// time and a negedge monitor compares them against what the DUT presents.
module tb_b_req_responder;

  logic        clk;
  logic        rst_n;
  logic        Valid;
  logic [11:0] Address;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_addr;
  logic [31:0] resp_data;
  logic [3:0]  fifo_level;
  logic        overflow_err;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   maxLevel    = 0;
  logic trackLevel  = 1'b0;

  b_req_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Valid        (Valid),
    .Address      (Address),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_addr    (resp_addr),
    .resp_data    (resp_data),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe.
  function automatic logic [31:0] memWord(input logic [11:0] a);
    return {20'hDEAD0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= memWord(mem_rd_addr);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [11:0] a, input logic accept);
    Valid   = v;
    Address = a;
    if (v && accept) expQ.push_back('{addr: a, data: memWord(a)});
    tick();
  endtask

  task automatic waitValid(input int maxCycles);
    int n = 0;
    while (!resp_valid && n < maxCycles) begin
      tick();
      n++;
    end
    if (!resp_valid) checkOutput("wait_resp_valid_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || resp_valid) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: every presented response is checked against the queue head; it is
  // popped only when the handshake will complete at the coming posedge.
  always @(negedge clk) begin
    if (trackLevel && int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
    if (rst_n && resp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_response", {20'd0, resp_addr, resp_data}, 64'd0);
      end else begin
        checkOutput("resp_addr", 64'(resp_addr), 64'(expQ[0].addr));
        checkOutput("resp_data", 64'(resp_data), 64'(expQ[0].data));
        if (resp_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int highCnt;
    rst_n      = 1'b0;
    Valid      = 1'b0;
    Address    = '0;
    resp_ready = 1'b1;
    mem_rd_data = '0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    checkOutput("rst_resp_addr", 64'(resp_addr), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst_overflow_err", 64'(overflow_err), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request latency
    applyStimulus(1'b1, 12'h0A5, 1'b1);
    Valid = 1'b0;
    checkOutput("t1_mem_rd_en", 64'(mem_rd_en), 64'd1);
    checkOutput("t1_mem_rd_addr", 64'(mem_rd_addr), 64'h0A5);
    checkOutput("t1_level_after_push", 64'(fifo_level), 64'd1);
    tick();
    checkOutput("t1_mem_rd_en_wait", 64'(mem_rd_en), 64'd0);
    checkOutput("t1_resp_valid_early", 64'(resp_valid), 64'd0);
    checkOutput("t1_level_after_pop", 64'(fifo_level), 64'd0);
    tick();
    checkOutput("t1_resp_valid", 64'(resp_valid), 64'd1);
    tick();
    checkOutput("t1_resp_valid_one_cycle", 64'(resp_valid), 64'd0);
    checkOutput("t1_queue_empty", 64'(expQ.size()), 64'd0);

    // Backpressure: held for five cycles, data stable (monitor checks each cycle)
    resp_ready = 1'b0;
    applyStimulus(1'b1, 12'h055, 1'b1);
    Valid = 1'b0;
    waitValid(10);
    highCnt = 0;
    repeat (5) begin
      if (resp_valid) highCnt++;
      tick();
    end
    if (resp_valid) highCnt++;
    resp_ready = 1'b1;
    tick();
    checkOutput("t2_valid_cycles", 64'(highCnt), 64'd6);
    checkOutput("t2_valid_dropped", 64'(resp_valid), 64'd0);
    checkOutput("t2_queue_empty", 64'(expQ.size()), 64'd0);

    // Ordering and pointer wrap, one request every three cycles
    maxLevel   = 0;
    trackLevel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 12'(i), 1'b1);
      Valid = 1'b0;
      tick();
      tick();
    end
    drain(20);
    trackLevel = 1'b0;
    checkOutput("t3_max_level", 64'(maxLevel), 64'd1);
    checkOutput("t3_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("t3_overflow_err", 64'(overflow_err), 64'd0);

    // Overflow: one in RESP, eight stored, last three dropped
    resp_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 12'h100 + 12'(i), i < 9);
    end
    Valid = 1'b0;
    checkOutput("t4_level_full", 64'(fifo_level), 64'd8);
    checkOutput("t4_overflow_err", 64'(overflow_err), 64'd1);
    checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'd3);

    // Push coincident with pop at full is accepted and answered last
    resp_ready = 1'b1;
    tick();
    applyStimulus(1'b1, 12'h3FF, 1'b1);
    Valid = 1'b0;
    checkOutput("t5_level_held", 64'(fifo_level), 64'd8);
    checkOutput("t5_drop_cnt", 64'(drop_cnt), 64'd3);
    drain(60);
    checkOutput("t5_overflow_sticky", 64'(overflow_err), 64'd1);
    checkOutput("t5_level_empty", 64'(fifo_level), 64'd0);

    // Reset while a response is pending and four are queued
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 12'h200 + 12'(i), 1'b1);
    end
    Valid = 1'b0;
    waitValid(10);
    checkOutput("t6_level_before_rst", 64'(fifo_level), 64'd4);
    rst_n = 1'b0;
    tick();
    expQ.delete();
    checkOutput("t6_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("t6_fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("t6_overflow_err", 64'(overflow_err), 64'd0);
    checkOutput("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("t6_mem_rd_en", 64'(mem_rd_en), 64'd0);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    highCnt = 0;
    repeat (10) begin
      tick();
      if (resp_valid || mem_rd_en) highCnt++;
    end
    checkOutput("t6_no_stale_activity", 64'(highCnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
